// File: rtl/raizing_eeprom93c46.sv
`default_nettype none
// raizing_eeprom93c46 -- 93C46-compatible 64x16 serial NVRAM responder with a parallel host port.
// Rev 1.0
module raizing_eeprom93c46 #(
  parameter int AW          = 6,
  parameter int DW          = 16,
  parameter int PROG_CYCLES = 4800,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          SCS,
  input  logic          SCLK,
  input  logic          SDI,
  output logic          SDO,
  output logic          BUSY,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_DIN,
  input  logic          HOST_WE,
  output logic [DW-1:0] HOST_DOUT,
  output logic          DIRTY,
  input  logic          DIRTY_CLR
);
  localparam int CW    = $clog2(DW);
  localparam int PW    = $clog2(PROG_CYCLES);
  localparam int WORDS = 1 << AW;

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADR, S_DIN, S_RDOUT, S_WAITCS, S_PROG} state_t;
  typedef enum logic [2:0] {C_READ, C_WRITE, C_ERASE, C_ERAL, C_WRAL, C_EWEN, C_EWDS} cmd_t;

  state_t                 state, state_n;
  cmd_t                   cmd, cmd_dec;
  logic [SYNC_STAGES-1:0] scs_q, sclk_q, sdi_q;
  logic                   sclk_d, scs_s, sdi_s, rise;
  logic [1:0]             op;
  logic [AW-1:0]          addr, adr_full, addr_inc;
  logic [DW-1:0]          shreg;
  logic [CW-1:0]          bitcnt;
  logic [PW-1:0]          prog_cnt;
  logic                   ewen, sdo, dirty, prog_enter;
  logic                   ser_we;
  logic [AW-1:0]          ser_addr;
  logic [DW-1:0]          ser_data;
  logic [DW-1:0]          mem [WORDS];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scs_q  <= '0;
      sclk_q <= '0;
      sdi_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      scs_q  <= {scs_q[SYNC_STAGES-2:0], SCS};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], SDI};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign scs_s    = scs_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_q[SYNC_STAGES-1];
  assign rise     = sclk_q[SYNC_STAGES-1] & ~sclk_d & scs_s;
  assign adr_full = {addr[AW-2:0], sdi_s};
  assign addr_inc = addr + AW'(1);

  // Opcode 00 is an extended command selected by the two address MSBs.
  always_comb begin
    cmd_dec = C_EWDS;
    case (op)
      2'b10:   cmd_dec = C_READ;
      2'b01:   cmd_dec = C_WRITE;
      2'b11:   cmd_dec = C_ERASE;
      default: begin
        case (adr_full[AW-1 -: 2])
          2'b11:   cmd_dec = C_EWEN;
          2'b10:   cmd_dec = C_ERAL;
          2'b01:   cmd_dec = C_WRAL;
          default: cmd_dec = C_EWDS;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    prog_enter = 1'b0;
    ser_we     = 1'b0;
    ser_addr   = addr;
    ser_data   = shreg;
    case (state)
      S_IDLE:   if (rise && sdi_s) state_n = S_OPC;
      S_OPC:    if (!scs_s) state_n = S_IDLE;
                else if (rise && bitcnt == CW'(1)) state_n = S_ADR;
      S_ADR: begin
        if (!scs_s) state_n = S_IDLE;
        else if (rise && bitcnt == CW'(AW-1)) begin
          case (cmd_dec)
            C_READ:          state_n = S_RDOUT;
            C_WRITE, C_WRAL: state_n = S_DIN;
            default:         state_n = S_WAITCS;
          endcase
        end
      end
      S_DIN:    if (!scs_s) state_n = S_IDLE;
                else if (rise && bitcnt == CW'(DW-1)) state_n = S_WAITCS;
      S_RDOUT:  if (!scs_s) state_n = S_IDLE;
      S_WAITCS: begin
        if (!scs_s) begin
          if (ewen && (cmd inside {C_WRITE, C_ERASE, C_ERAL, C_WRAL})) begin
            state_n    = S_PROG;
            prog_enter = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_PROG:   if (prog_cnt == PW'(PROG_CYCLES-1)) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    if (prog_enter && (cmd == C_WRITE || cmd == C_ERASE)) begin
      ser_we   = 1'b1;
      ser_data = (cmd == C_ERASE) ? {DW{1'b1}} : shreg;
    end
    // Bulk commands sweep the array one word per clock at the start of the busy period.
    if (state == S_PROG && (cmd == C_ERAL || cmd == C_WRAL) && prog_cnt < PW'(WORDS)) begin
      ser_we   = 1'b1;
      ser_addr = prog_cnt[AW-1:0];
      ser_data = (cmd == C_ERAL) ? {DW{1'b1}} : shreg;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cmd      <= C_READ;
      op       <= 2'b00;
      addr     <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      prog_cnt <= '0;
      ewen     <= 1'b0;
      sdo      <= 1'b1;
      dirty    <= 1'b0;
    end else begin
      if (prog_enter)     dirty <= 1'b1;
      else if (DIRTY_CLR) dirty <= 1'b0;

      case (state)
        S_IDLE: begin
          sdo      <= 1'b1;
          bitcnt   <= '0;
          prog_cnt <= '0;
        end
        S_OPC: begin
          if (!scs_s) sdo <= 1'b1;
          else if (rise) begin
            op     <= {op[0], sdi_s};
            bitcnt <= (bitcnt == CW'(1)) ? '0 : bitcnt + CW'(1);
          end
        end
        S_ADR: begin
          if (!scs_s) sdo <= 1'b1;
          else if (rise) begin
            addr   <= adr_full;
            bitcnt <= bitcnt + CW'(1);
            if (bitcnt == CW'(AW-1)) begin
              bitcnt <= '0;
              cmd    <= cmd_dec;
              if (cmd_dec == C_READ) begin
                sdo   <= 1'b0;
                shreg <= mem[adr_full];
              end
              if (cmd_dec == C_EWEN) ewen <= 1'b1;
              if (cmd_dec == C_EWDS) ewen <= 1'b0;
            end
          end
        end
        S_DIN: begin
          if (!scs_s) sdo <= 1'b1;
          else if (rise) begin
            shreg  <= {shreg[DW-2:0], sdi_s};
            bitcnt <= (bitcnt == CW'(DW-1)) ? '0 : bitcnt + CW'(1);
          end
        end
        S_RDOUT: begin
          if (!scs_s) sdo <= 1'b1;
          else if (rise) begin
            sdo    <= shreg[DW-1];
            shreg  <= {shreg[DW-2:0], 1'b0};
            bitcnt <= bitcnt + CW'(1);
            if (bitcnt == CW'(DW-1)) begin
              bitcnt <= '0;
              addr   <= addr_inc;
              shreg  <= mem[addr_inc];
            end
          end
        end
        S_WAITCS: begin
          sdo      <= 1'b1;
          prog_cnt <= '0;
        end
        S_PROG: begin
          prog_cnt <= prog_cnt + PW'(1);
          sdo      <= (state_n == S_IDLE) ? 1'b1 : ~scs_s;
        end
        default: sdo <= 1'b1;
      endcase
    end
  end

  // Serial commits take priority; a colliding host write is dropped.
  always_ff @(posedge CLK) begin
    if (ser_we)       mem[ser_addr]  <= ser_data;
    else if (HOST_WE) mem[HOST_ADDR] <= HOST_DIN;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) HOST_DOUT <= '0;
    else          HOST_DOUT <= mem[HOST_ADDR];
  end

  assign SDO   = sdo;
  assign BUSY  = (state == S_PROG);
  assign DIRTY = dirty;

endmodule
`default_nettype wire

// File: tb/tb_raizing_eeprom93c46.sv
`default_nettype none
// tb_raizing_eeprom93c46 -- directed serial/host stimulus with a queue-based scoreboard.
module tb_raizing_eeprom93c46;
  logic        CLK = 1'b0, RESET_N = 1'b0, SCS = 1'b0, SCLK = 1'b0, SDI = 1'b0;
  logic        HOST_WE = 1'b0, DIRTY_CLR = 1'b0;
  logic [5:0]  HOST_ADDR = 6'd0;
  logic [15:0] HOST_DIN = 16'h0;
  logic        SDO, BUSY, DIRTY;
  logic [15:0] HOST_DOUT;

  always #5 CLK = ~CLK;

  raizing_eeprom93c46 dut (
    .CLK(CLK), .RESET_N(RESET_N), .SCS(SCS), .SCLK(SCLK), .SDI(SDI), .SDO(SDO),
    .BUSY(BUSY), .HOST_ADDR(HOST_ADDR), .HOST_DIN(HOST_DIN), .HOST_WE(HOST_WE),
    .HOST_DOUT(HOST_DOUT), .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR)
  );

  typedef enum int {K_SDO, K_BUSY, K_DIRTY, K_HDOUT} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [15:0] exp;
  } chk_t;

  chk_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string name, input kind_t kind, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    exp_q.push_back(c);
    -> chk_ev;
  endtask

  initial begin : monitor
    chk_t        c;
    logic [15:0] act;
    forever begin
      @(chk_ev);
      while (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        case (c.kind)
          K_SDO:   act = {15'b0, SDO};
          K_BUSY:  act = {15'b0, BUSY};
          K_DIRTY: act = {15'b0, DIRTY};
          default: act = HOST_DOUT;
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sbit(input logic b);
    SDI = b;
    tick(4);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [5:0] a);
    SCS = 1'b1;
    tick(2);
    sbit(1'b1);
    sbit(op[1]);
    sbit(op[0]);
    for (int i = 5; i >= 0; i--) sbit(a[i]);
  endtask

  task automatic send_word(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) sbit(d[i]);
  endtask

  task automatic cs_low();
    SCS = 1'b0;
    tick(4);
  endtask

  task automatic ewen();
    cmd(2'b00, 6'b110000);
    cs_low();
  endtask

  task automatic hwrite(input logic [5:0] a, input logic [15:0] d);
    HOST_ADDR = a;
    HOST_DIN  = d;
    HOST_WE   = 1'b1;
    tick(1);
    HOST_WE   = 1'b0;
  endtask

  task automatic hread(input logic [5:0] a, input logic [15:0] exp, input string name);
    HOST_ADDR = a;
    tick(1);
    expect_out(name, K_HDOUT, exp);
  endtask

  task automatic read_words(input logic [5:0] a, input logic [15:0] w0, input logic [15:0] w1,
                            input int nwords);
    logic [15:0] d;
    cmd(2'b10, a);
    expect_out("read dummy bit", K_SDO, 16'h0);
    for (int w = 0; w < nwords; w++) begin
      d = (w == 0) ? w0 : w1;
      for (int b = 15; b >= 0; b--) begin
        sbit(1'b0);
        expect_out($sformatf("read a%0d w%0d b%0d", a, w, b), K_SDO, {15'b0, d[b]});
      end
    end
    cs_low();
  endtask

  task automatic wait_prog_done(input string name);
    int n;
    n = 0;
    while (!BUSY && n < 50) begin tick(1); n++; end
    n = 0;
    while (BUSY && n < 6000) begin tick(1); n++; end
    expect_out(name, K_BUSY, 16'h0);
  endtask

  initial begin : stim
    int n, len;
    tick(3);
    expect_out("reset sdo", K_SDO, 16'h1);
    expect_out("reset busy", K_BUSY, 16'h0);
    expect_out("reset host_dout", K_HDOUT, 16'h0);
    expect_out("reset dirty", K_DIRTY, 16'h0);
    RESET_N = 1'b1;
    tick(2);

    // EWEN + WRITE, busy period measured with SCS raised to poll ready/busy
    ewen();
    cmd(2'b01, 6'd5);
    send_word(16'hA55A);
    SCS = 1'b0;
    n = 0;
    while (!BUSY && n < 20) begin tick(1); n++; end
    len = 0;
    while (BUSY && len < 6000) begin
      len++;
      if (len == 10) SCS = 1'b1;
      if (len == 20) expect_out("prog sdo busy", K_SDO, 16'h0);
      tick(1);
    end
    check_val("busy length", len, 4800);
    expect_out("prog sdo ready", K_SDO, 16'h1);
    expect_out("dirty after write", K_DIRTY, 16'h1);
    SCS = 1'b0;
    tick(4);
    read_words(6'd5, 16'hA55A, 16'h0, 1);
    hread(6'd5, 16'hA55A, "host word5");

    // Write after EWDS is ignored
    DIRTY_CLR = 1'b1;
    tick(1);
    DIRTY_CLR = 1'b0;
    expect_out("dirty cleared", K_DIRTY, 16'h0);
    hwrite(6'd3, 16'h3333);
    cmd(2'b00, 6'b000000);
    cs_low();
    cmd(2'b01, 6'd3);
    send_word(16'h1111);
    SCS = 1'b0;
    tick(30);
    expect_out("ewds no busy", K_BUSY, 16'h0);
    hread(6'd3, 16'h3333, "ewds word3 kept");
    expect_out("ewds dirty", K_DIRTY, 16'h0);

    // Streaming read wraps 63 -> 0
    hwrite(6'd63, 16'h1234);
    hwrite(6'd0, 16'hBEEF);
    read_words(6'd63, 16'h1234, 16'hBEEF, 2);

    // WRAL then ERAL
    ewen();
    cmd(2'b00, 6'b010000);
    send_word(16'h00FF);
    SCS = 1'b0;
    wait_prog_done("wral done");
    expect_out("wral dirty", K_DIRTY, 16'h1);
    for (int a = 0; a < 64; a++) hread(6'(a), 16'h00FF, $sformatf("wral word%0d", a));
    cmd(2'b00, 6'b100000);
    SCS = 1'b0;
    wait_prog_done("eral done");
    for (int a = 0; a < 64; a++) hread(6'(a), 16'hFFFF, $sformatf("eral word%0d", a));

    // WRITE aborted after 8 data bits
    hwrite(6'd7, 16'h7777);
    cmd(2'b01, 6'd7);
    for (int i = 0; i < 8; i++) sbit(i[0]);
    SCS = 1'b0;
    tick(30);
    expect_out("abort no busy", K_BUSY, 16'h0);
    expect_out("abort sdo", K_SDO, 16'h1);
    hread(6'd7, 16'h7777, "abort word7 kept");

    // Reset mid-PROG, then EWEN latch must be re-issued
    cmd(2'b01, 6'd9);
    send_word(16'h5555);
    SCS = 1'b0;
    n = 0;
    while (!BUSY && n < 20) begin tick(1); n++; end
    tick(100);
    RESET_N = 1'b0;
    tick(1);
    expect_out("reset mid-prog busy", K_BUSY, 16'h0);
    expect_out("reset mid-prog sdo", K_SDO, 16'h1);
    tick(2);
    RESET_N = 1'b1;
    tick(2);
    hwrite(6'd10, 16'hAAAA);
    cmd(2'b01, 6'd10);
    send_word(16'h1234);
    SCS = 1'b0;
    tick(30);
    expect_out("post-reset no busy", K_BUSY, 16'h0);
    hread(6'd10, 16'hAAAA, "post-reset word10 kept");
    ewen();
    cmd(2'b01, 6'd10);
    send_word(16'h1234);
    SCS = 1'b0;
    wait_prog_done("post-ewen write done");
    hread(6'd10, 16'h1234, "post-ewen word10");

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
